// File: rtl/lr_cb_exec.sv
// LR35902 CB-prefix sequencer: rotate/shift/swap via lr_alu, BIT/RES/SET locally.
// Define LR_CB_TIMING_EN to pad completion to real T-state counts via a HOLD state.
module lr_cb_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  cb_op,
   input  logic [15:0] hl,
   output logic        busy,
   output logic        done,
   output logic [2:0]  reg_rd_sel,
   input  logic [7:0]  reg_rd_data,
   output logic        reg_wr_en,
   output logic [2:0]  reg_wr_sel,
   output logic [7:0]  reg_wr_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [4:0]  alu_op,
   output logic [15:0] alu_a,
   output logic        alu_c,
   input  logic [15:0] alu_d,
   input  logic        alu_z,
   input  logic        alu_nc,
   input  logic [3:0]  flags_in,
   output logic [3:0]  flags_out,
   output logic        flags_we
);

   localparam int unsigned ALU_OP_W = 5;
   localparam logic [2:0]  TGT_HL   = 3'd6;
   localparam logic [2:0]  SEL_SWAP = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_EX   = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
`ifdef LR_CB_TIMING_EN
      , S_HOLD = 3'd5
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  op_q;
   logic [15:0] hl_q;
   logic [7:0]  opnd_q;
   logic [7:0]  res_q;
   logic [3:0]  flags_q;

   logic [2:0]  sel, tgt;
   logic        is_mem, is_shift, is_bit, is_res;
   logic [7:0]  mask;
   logic        rd_fin, wb_fin;
   logic [ALU_OP_W-1:0] shift_op;
   logic [7:0]  ex_result;
   logic [3:0]  ex_flags;
   logic        unused_bits;

   assign sel      = op_q[5:3];
   assign tgt      = op_q[2:0];
   assign is_mem   = (tgt == TGT_HL);
   assign is_shift = (op_q[7:6] == 2'b00);
   assign is_bit   = (op_q[7:6] == 2'b01);
   assign is_res   = (op_q[7:6] == 2'b10);
   assign mask     = 8'h01 << sel;
   assign rd_fin   = !is_mem || mem_ack;
   assign wb_fin   = is_bit || !is_mem || mem_ack;
   assign unused_bits = ^{alu_d[15:8], flags_in[3:1]};

   // Shift-group select to lr_alu op code
   always_comb begin
      shift_op = 5'h00;
      case (sel)
         3'd0: shift_op = 5'h09;
         3'd1: shift_op = 5'h0b;
         3'd2: shift_op = 5'h0a;
         3'd3: shift_op = 5'h0c;
         3'd4: shift_op = 5'h0d;
         3'd5: shift_op = 5'h0e;
         3'd6: shift_op = 5'h10;
         3'd7: shift_op = 5'h0f;
         default: shift_op = 5'h00;
      endcase
   end

   always_comb begin
      ex_result = opnd_q;
      ex_flags  = flags_q;
      if (is_shift) begin
         ex_result = alu_d[7:0];
         ex_flags  = {alu_z, 1'b0, 1'b0, (sel == SEL_SWAP) ? 1'b0 : alu_nc};
      end else if (is_bit) begin
         ex_flags  = {~opnd_q[sel], 1'b0, 1'b1, flags_in[0]};
      end else if (is_res) begin
         ex_result = opnd_q & ~mask;
      end else begin
         ex_result = opnd_q | mask;
      end
   end

`ifdef LR_CB_TIMING_EN
   logic [4:0] cnt_q;
   logic [4:0] budget;
   logic       pad_done;

   assign budget   = is_mem ? (is_bit ? 5'd12 : 5'd16) : 5'd8;
   // cnt_q equals the cycle offset from the accepting IDLE cycle
   assign pad_done = (cnt_q >= budget - 5'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 5'd0;
      end else if (state == S_IDLE) begin
         cnt_q <= start ? 5'd1 : 5'd0;
      end else if (cnt_q != 5'd31) begin
         cnt_q <= cnt_q + 5'd1;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start)  state_nxt = S_RD;
         S_RD:   if (rd_fin) state_nxt = S_EX;
         S_EX:   state_nxt = S_WB;
`ifdef LR_CB_TIMING_EN
         S_WB:   if (wb_fin) state_nxt = pad_done ? S_DONE : S_HOLD;
         S_HOLD: if (pad_done) state_nxt = S_DONE;
`else
         S_WB:   if (wb_fin) state_nxt = S_DONE;
`endif
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operation capture, operand fetch and execute latches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= 8'h00;
         hl_q    <= 16'h0000;
         opnd_q  <= 8'h00;
         res_q   <= 8'h00;
         flags_q <= 4'h0;
      end else begin
         if (state == S_IDLE && start) begin
            op_q <= cb_op;
            hl_q <= hl;
         end
         if (state == S_RD && rd_fin)
            opnd_q <= is_mem ? mem_rdata : reg_rd_data;
         if (state == S_EX) begin
            res_q <= ex_result;
            if (is_shift || is_bit) flags_q <= ex_flags;
         end
      end
   end

   always_comb begin
      busy        = (state != S_IDLE);
      done        = 1'b0;
      reg_rd_sel  = 3'd0;
      reg_wr_en   = 1'b0;
      reg_wr_sel  = 3'd0;
      reg_wr_data = 8'h00;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 16'h0000;
      mem_wdata   = 8'h00;
      alu_op      = 5'h00;
      alu_a       = 16'h0000;
      alu_c       = 1'b0;
      flags_out   = flags_q;
      flags_we    = 1'b0;
      case (state)
         S_RD: begin
            if (is_mem) begin
               mem_req  = 1'b1;
               mem_addr = hl_q;
            end else begin
               reg_rd_sel = tgt;
            end
         end
         S_EX: begin
            if (is_shift) begin
               alu_op = shift_op;
               alu_a  = {8'h00, opnd_q};
               alu_c  = flags_in[0];
            end
         end
         S_WB: begin
            if (is_bit) begin
               flags_we = 1'b1;
            end else if (!is_mem) begin
               reg_wr_en   = 1'b1;
               reg_wr_sel  = tgt;
               reg_wr_data = res_q;
               flags_we    = is_shift;
            end else begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = hl_q;
               mem_wdata = res_q;
               flags_we  = is_shift && mem_ack;
            end
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lr_cb_exec.sv
// Directed-vector bench for lr_cb_exec with a behavioural ALU, register file and wait-state memory.
module tb_lr_cb_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  cb_op;
   logic [15:0] hl;
   logic        busy, done;
   logic [2:0]  reg_rd_sel;
   logic [7:0]  reg_rd_data;
   logic        reg_wr_en;
   logic [2:0]  reg_wr_sel;
   logic [7:0]  reg_wr_data;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_ack;
   logic [4:0]  alu_op;
   logic [15:0] alu_a;
   logic        alu_c;
   logic [15:0] alu_d;
   logic        alu_z, alu_nc;
   logic [3:0]  flags_in, flags_out;
   logic        flags_we;

   lr_cb_exec dut (
      .clk(clk), .rst(rst), .start(start), .cb_op(cb_op), .hl(hl),
      .busy(busy), .done(done),
      .reg_rd_sel(reg_rd_sel), .reg_rd_data(reg_rd_data),
      .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .alu_op(alu_op), .alu_a(alu_a), .alu_c(alu_c),
      .alu_d(alu_d), .alu_z(alu_z), .alu_nc(alu_nc),
      .flags_in(flags_in), .flags_out(flags_out), .flags_we(flags_we)
   );

   always #5 clk = ~clk;

   logic [7:0] rf [8];
   logic [7:0] mem [256];
   int         waits = 0;
   logic [4:0] wcnt;
   int cyc = 0, n_cyc = -1, done_cyc = -1;
   int done_cnt = 0, fwe_cnt = 0, rwr = 0, mwr = 0;
   int n_chk = 0, n_fail = 0;

   assign reg_rd_data = rf[reg_rd_sel];
   assign mem_rdata   = mem[mem_addr[7:0]];
   assign mem_ack     = mem_req && (wcnt == 5'(waits));

   // Reference lr_alu shift/rotate/swap behaviour
   always_comb begin
      logic [7:0] a, r;
      logic       c;
      a = alu_a[7:0];
      r = 8'h00;
      c = 1'b0;
      case (alu_op)
         5'h09: begin r = {a[6:0], a[7]};  c = a[7]; end
         5'h0a: begin r = {a[6:0], alu_c}; c = a[7]; end
         5'h0b: begin r = {a[0], a[7:1]};  c = a[0]; end
         5'h0c: begin r = {alu_c, a[7:1]}; c = a[0]; end
         5'h0d: begin r = {a[6:0], 1'b0};  c = a[7]; end
         5'h0e: begin r = {a[7], a[7:1]};  c = a[0]; end
         5'h0f: begin r = {1'b0, a[7:1]};  c = a[0]; end
         5'h10: begin r = {a[3:0], a[7:4]}; c = 1'b0; end
         default: ;
      endcase
      alu_d  = {8'h00, r};
      alu_z  = (r == 8'h00);
      alu_nc = c;
   end

   always @(posedge clk or posedge rst) begin
      if (rst)                     wcnt <= 5'd0;
      else if (mem_req && !mem_ack) wcnt <= wcnt + 5'd1;
      else                         wcnt <= 5'd0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (start && !busy && !rst) n_cyc = cyc;
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (flags_we) fwe_cnt++;
      if (reg_wr_en) begin rf[reg_wr_sel] = reg_wr_data; rwr++; end
      if (mem_req && mem_we && mem_ack) begin mem[mem_addr[7:0]] = mem_wdata; mwr++; end
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [15:0] hl;
      logic [7:0]  init;
      logic [3:0]  fin;
      int          waits;
      logic [7:0]  exp_data;
      logic [3:0]  exp_flags;
      int          exp_fwe;
      int          exp_wr;
      int          lat;
      int          lat_t;
   } vec_t;

   task automatic run_op(input vec_t v, input string tag);
      logic got;
      int   lat_exp;
      got = 1'b0;
      if (v.op[2:0] == 3'd6) mem[v.hl[7:0]] = v.init;
      else                   rf[v.op[2:0]] = v.init;
      flags_in = v.fin;
      waits    = v.waits;
      fwe_cnt = 0; rwr = 0; mwr = 0; done_cnt = 0; n_cyc = -1; done_cyc = -1;
      @(posedge clk); #1;
      cb_op = v.op; hl = v.hl; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      @(negedge clk);
      check({tag, " done_seen"}, int'(got), 1);
`ifdef LR_CB_TIMING_EN
      lat_exp = v.lat_t;
`else
      lat_exp = v.lat;
`endif
      check({tag, " latency"}, done_cyc - n_cyc, lat_exp);
      check({tag, " flags_out"}, int'(flags_out), int'(v.exp_flags));
      check({tag, " flags_we_count"}, fwe_cnt, v.exp_fwe);
      check({tag, " data_writes"}, rwr + mwr, v.exp_wr);
      if (v.op[2:0] == 3'd6) check({tag, " mem_data"}, int'(mem[v.hl[7:0]]), int'(v.exp_data));
      else                   check({tag, " reg_data"}, int'(rf[v.op[2:0]]), int'(v.exp_data));
   endtask

   vec_t vecs [13];
   vec_t post;

   initial begin
      logic seen;
      rst = 1'b1; start = 1'b0; cb_op = 8'h00; hl = 16'h0000; flags_in = 4'h0;
      for (int i = 0; i < 8; i++)   rf[i] = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      //          op     hl        init   fin  w  data   flg  fwe wr lat lat_t
      vecs[0]  = '{8'h00, 16'h0000, 8'h85, 4'h0, 0, 8'h0B, 4'h1, 1, 1, 4, 8};
      vecs[1]  = '{8'h1F, 16'h0000, 8'h01, 4'h0, 0, 8'h00, 4'h9, 1, 1, 4, 8};
      vecs[2]  = '{8'h17, 16'h0000, 8'h80, 4'h1, 0, 8'h01, 4'h1, 1, 1, 4, 8};
      vecs[3]  = '{8'h36, 16'hC000, 8'hF0, 4'h0, 2, 8'h0F, 4'h0, 1, 1, 8, 16};
      vecs[4]  = '{8'h7C, 16'h0000, 8'h7F, 4'h1, 0, 8'h7F, 4'hB, 1, 0, 4, 8};
      vecs[5]  = '{8'h83, 16'h0000, 8'hFF, 4'h0, 0, 8'hFE, 4'hB, 0, 1, 4, 8};
      vecs[6]  = '{8'hDE, 16'hC010, 8'h40, 4'h0, 0, 8'h48, 4'hB, 0, 1, 4, 16};
      vecs[7]  = '{8'h2A, 16'h0000, 8'h81, 4'h0, 0, 8'hC0, 4'h1, 1, 1, 4, 8};
      vecs[8]  = '{8'h3D, 16'h0000, 8'h01, 4'h0, 0, 8'h00, 4'h9, 1, 1, 4, 8};
      vecs[9]  = '{8'h46, 16'hC020, 8'h01, 4'h0, 0, 8'h01, 4'h2, 1, 0, 4, 12};
      vecs[10] = '{8'h21, 16'h0000, 8'h80, 4'h0, 0, 8'h00, 4'h9, 1, 1, 4, 8};
      vecs[11] = '{8'h0F, 16'h0000, 8'h01, 4'h0, 0, 8'h80, 4'h1, 1, 1, 4, 8};
      vecs[12] = '{8'hBE, 16'hC030, 8'hFF, 4'h0, 1, 8'h7F, 4'h1, 0, 1, 6, 16};

      #1;
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset mem_req", int'(mem_req), 0);
      check("reset alu_op", int'(alu_op), 0);
      check("reset flags_out", int'(flags_out), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // start held through the whole operation must be accepted once only
      rf[0] = 8'h85; flags_in = 4'h0; waits = 0;
      rwr = 0; done_cnt = 0; seen = 1'b0;
      @(posedge clk); #1;
      cb_op = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      cb_op = 8'h80;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("hold_start done_seen", int'(seen), 1);
      check("hold_start done_count", done_cnt, 1);
      check("hold_start reg_writes", rwr, 1);
      check("hold_start reg_b", int'(rf[0]), 8'h0B);
      check("hold_start busy", int'(busy), 0);

      // reset while a memory write is waiting for its ack
      mem[8'h40] = 8'h11; waits = 20; mwr = 0; seen = 1'b0;
      @(posedge clk); #1;
      cb_op = 8'hC6; hl = 16'hC040; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (mem_req && mem_we) begin seen = 1'b1; break; end
      end
      check("rst_mid wb_reached", int'(seen), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid mem_req", int'(mem_req), 0);
      check("rst_mid mem_we", int'(mem_we), 0);
      check("rst_mid busy", int'(busy), 0);
      check("rst_mid done", int'(done), 0);
      check("rst_mid flags_out", int'(flags_out), 0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid no_write", mwr, 0);
      check("rst_mid mem_kept", int'(mem[8'h40]), 8'h11);

      post = '{8'hDE, 16'hC010, 8'h40, 4'h0, 0, 8'h48, 4'h0, 0, 1, 4, 16};
      run_op(post, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
